// File: rtl/clock_disp_ctrl.sv
// Mode/edit controller for the 8-digit clock display.
// Live/edit display mux, time-set and alarm-set FSM, field blink, idle abort.
module clock_disp_ctrl #(
  parameter int unsigned BLINK_HALF = 12_500_000,
  parameter int unsigned TIMEOUT    = 500_000_000,
  parameter logic [3:0]  SEP        = 4'hA,
  parameter logic [3:0]  BLANK      = 4'hF,
  parameter logic [23:0] ALARM_RST  = 24'h070000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [23:0] Time_BCD,
  input  logic        Key_Mode,
  input  logic        Key_Next,
  input  logic        Key_Up,
  output logic [31:0] Disp_Data,
  output logic [23:0] Set_Time,
  output logic        Set_Time_Load,
  output logic [23:0] Alarm_BCD,
  output logic [1:0]  Mode
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_SHOW  = 2'd0,
    S_TIME  = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    F_HH = 2'd0,
    F_MM = 2'd1,
    F_SS = 2'd2
  } field_t;

  state_t        r_state, w_state_n;
  field_t        r_field, w_field_n;
  logic [23:0]   r_buf, w_buf_n;
  logic [23:0]   r_alarm, w_alarm_n;
  logic [23:0]   r_set, w_set_n;
  logic          r_load, w_load_n;
  logic [31:0]   r_disp, w_disp_n;
  logic [31:0]   r_idle, w_idle_n;
  logic [BW-1:0] r_bcnt, w_bcnt_n;
  logic          r_phase, w_phase_n;

  logic        w_edit;
  logic        w_any;
  logic        w_mode;
  logic        w_next;
  logic        w_up;
  logic [23:0] w_src;
  logic [7:0]  w_hh;
  logic [7:0]  w_mm;
  logic [7:0]  w_ss;

  // Wraps at lim; the buffer only ever holds valid BCD.
  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] lim
  );
    logic [7:0] res;
    if (v == lim)
      res = 8'h00;
    else if (v[3:0] == 4'd9)
      res = {v[7:4] + 4'd1, 4'd0};
    else
      res = {v[7:4], v[3:0] + 4'd1};
    return res;
  endfunction

  assign w_edit = (r_state != S_SHOW);
  assign w_any  = Key_Mode | Key_Next | Key_Up;
  assign w_mode = Key_Mode;
  assign w_next = Key_Next & ~Key_Mode;
  assign w_up   = Key_Up & ~Key_Mode & ~Key_Next;

  always_comb begin
    w_state_n = r_state;
    w_field_n = r_field;
    w_buf_n   = r_buf;
    w_alarm_n = r_alarm;
    w_set_n   = r_set;
    w_load_n  = 1'b0;
    w_idle_n  = r_idle;
    w_bcnt_n  = r_bcnt;
    w_phase_n = r_phase;

    unique case (r_state)
      S_SHOW: begin
        if (w_mode) begin
          w_state_n = S_TIME;
          w_buf_n   = Time_BCD;
          w_field_n = F_HH;
        end
      end
      S_TIME: begin
        if (w_mode) begin
          w_state_n = S_ALARM;
          w_set_n   = r_buf;
          w_load_n  = 1'b1;
          w_buf_n   = r_alarm;
          w_field_n = F_HH;
        end
      end
      S_ALARM: begin
        if (w_mode) begin
          w_state_n = S_SHOW;
          w_alarm_n = r_buf;
        end
      end
      default: w_state_n = S_SHOW;
    endcase

    if (w_edit && !w_mode) begin
      unique case (1'b1)
        w_next: begin
          unique case (r_field)
            F_HH:    w_field_n = F_MM;
            F_MM:    w_field_n = F_SS;
            default: w_field_n = F_HH;
          endcase
        end
        w_up: begin
          unique case (r_field)
            F_HH: w_buf_n[23:16] = bcd_inc(r_buf[23:16], 8'h23);
            F_MM: w_buf_n[15:8]  = bcd_inc(r_buf[15:8], 8'h59);
            F_SS: w_buf_n[7:0]   = bcd_inc(r_buf[7:0], 8'h59);
            default: ;
          endcase
        end
        default: ;
      endcase
    end

    // Idle and blink counters share the "since last key" notion.
    if (!w_edit || w_any) begin
      w_idle_n  = '0;
      w_bcnt_n  = '0;
      w_phase_n = 1'b1;
    end else if (r_idle == IDLE_LAST) begin
      w_state_n = S_SHOW;
      w_idle_n  = '0;
      w_bcnt_n  = '0;
      w_phase_n = 1'b1;
    end else begin
      w_idle_n = r_idle + 32'd1;
      if (r_bcnt == BLK_LAST) begin
        w_bcnt_n  = '0;
        w_phase_n = ~r_phase;
      end else begin
        w_bcnt_n = r_bcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_src = w_edit ? r_buf : Time_BCD;
    w_hh  = w_src[23:16];
    w_mm  = w_src[15:8];
    w_ss  = w_src[7:0];
    if (w_edit && !r_phase) begin
      unique case (r_field)
        F_HH: w_hh = {BLANK, BLANK};
        F_MM: w_mm = {BLANK, BLANK};
        F_SS: w_ss = {BLANK, BLANK};
        default: ;
      endcase
    end
    w_disp_n = {w_hh, SEP, w_mm, SEP, w_ss};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_SHOW;
      r_field <= F_HH;
      r_buf   <= '0;
      r_alarm <= ALARM_RST;
      r_set   <= '0;
      r_load  <= 1'b0;
      r_disp  <= '0;
      r_idle  <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_field <= w_field_n;
      r_buf   <= w_buf_n;
      r_alarm <= w_alarm_n;
      r_set   <= w_set_n;
      r_load  <= w_load_n;
      r_disp  <= w_disp_n;
      r_idle  <= w_idle_n;
      r_bcnt  <= w_bcnt_n;
      r_phase <= w_phase_n;
    end
  end

  assign Disp_Data     = r_disp;
  assign Set_Time      = r_set;
  assign Set_Time_Load = r_load;
  assign Alarm_BCD     = r_alarm;
  assign Mode          = r_state;

endmodule

// File: tb/tb_clock_disp_ctrl.sv
// Bench for clock_disp_ctrl: directed scenarios then random keys,
// checked every cycle against a field-level model of the controller.
module tb_clock_disp_ctrl;

  localparam int BH = 4;
  localparam int TO = 64;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [23:0] Time_BCD;
  logic        Key_Mode = 1'b0;
  logic        Key_Next = 1'b0;
  logic        Key_Up = 1'b0;
  logic [31:0] Disp_Data;
  logic [23:0] Set_Time;
  logic        Set_Time_Load;
  logic [23:0] Alarm_BCD;
  logic [1:0]  Mode;

  clock_disp_ctrl #(
    .BLINK_HALF(BH),
    .TIMEOUT(TO)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Time_BCD(Time_BCD),
    .Key_Mode(Key_Mode),
    .Key_Next(Key_Next),
    .Key_Up(Key_Up),
    .Disp_Data(Disp_Data),
    .Set_Time(Set_Time),
    .Set_Time_Load(Set_Time_Load),
    .Alarm_BCD(Alarm_BCD),
    .Mode(Mode)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  int          t_t[3];
  int          m_st;
  int          m_fld;
  int          m_quiet;
  int          m_buf[3];
  int          m_alm[3];
  int          m_set[3];
  logic        m_load;
  logic [31:0] m_disp;

  function automatic logic [7:0] b2(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [23:0] pk(input int h, input int m, input int s);
    return {b2(h), b2(m), b2(s)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st    = 0;
    m_fld   = 0;
    m_quiet = 0;
    m_buf   = '{0, 0, 0};
    m_alm   = '{7, 0, 0};
    m_set   = '{0, 0, 0};
    m_load  = 1'b0;
    m_disp  = '0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t_t      = '{h, m, s};
    Time_BCD = pk(h, m, s);
  endtask

  task automatic m_step(input bit km, input bit kn, input bit ku);
    int         f[3];
    logic [7:0] by[3];
    bit         on;
    on = ((m_quiet / BH) % 2) == 0;
    for (int i = 0; i < 3; i++) begin
      f[i]  = (m_st == 0) ? t_t[i] : m_buf[i];
      by[i] = (m_st != 0 && !on && m_fld == i) ? 8'hFF : b2(f[i]);
    end
    m_disp = {by[0], 4'hA, by[1], 4'hA, by[2]};
    m_load = 1'b0;
    if (m_st == 0) begin
      m_quiet = 0;
      if (km) begin
        m_st  = 1;
        m_buf = t_t;
        m_fld = 0;
      end
    end else if (km) begin
      if (m_st == 1) begin
        m_set  = m_buf;
        m_load = 1'b1;
        m_buf  = m_alm;
        m_fld  = 0;
        m_st   = 2;
      end else begin
        m_alm = m_buf;
        m_st  = 0;
      end
      m_quiet = 0;
    end else if (kn) begin
      m_fld   = (m_fld + 1) % 3;
      m_quiet = 0;
    end else if (ku) begin
      m_buf[m_fld] = (m_buf[m_fld] + 1) % ((m_fld == 0) ? 24 : 60);
      m_quiet = 0;
    end else if (m_quiet == TO - 1) begin
      m_st    = 0;
      m_quiet = 0;
    end else begin
      m_quiet++;
    end
  endtask

  task automatic tick(input bit km = 1'b0, input bit kn = 1'b0,
                      input bit ku = 1'b0);
    Key_Mode = km;
    Key_Next = kn;
    Key_Up   = ku;
    m_step(km, kn, ku);
    @(posedge Clk);
    #1;
    Key_Mode = 1'b0;
    Key_Next = 1'b0;
    Key_Up   = 1'b0;
    chk("disp", Disp_Data, m_disp);
    chk("mode", 32'(Mode), 32'(m_st));
    chk("load", 32'(Set_Time_Load), 32'(m_load));
    chk("set", 32'(Set_Time), 32'(pk(m_set[0], m_set[1], m_set[2])));
    chk("alarm", 32'(Alarm_BCD), 32'(pk(m_alm[0], m_alm[1], m_alm[2])));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_disp"}, Disp_Data, 32'h0);
    chk({tag, "_mode"}, 32'(Mode), 32'd0);
    chk({tag, "_load"}, 32'(Set_Time_Load), 32'd0);
    chk({tag, "_set"}, 32'(Set_Time), 32'h0);
    chk({tag, "_alarm"}, 32'(Alarm_BCD), 32'h070000);
  endtask

  initial begin
    bit km;
    bit kn;
    bit ku;
    int r;
    bit dense;

    set_time(12, 34, 56);
    m_reset();
    @(posedge Clk);
    #1;
    chk_reset("rst");
    Reset_n = 1'b1;

    tick();
    chk("t1_disp", Disp_Data, 32'h12A34A56);

    tick(1, 0, 0);
    repeat (5) tick(0, 0, 1);
    tick(0, 1, 0);
    tick(0, 0, 1);
    tick(1, 0, 0);
    chk("t2_set", 32'(Set_Time), 32'h173556);
    chk("t2_load", 32'(Set_Time_Load), 32'd1);
    chk("t2_mode", 32'(Mode), 32'd2);
    tick();
    chk("t2_load_drop", 32'(Set_Time_Load), 32'd0);
    tick(1, 0, 0);

    set_time(23, 59, 10);
    tick(1, 0, 0);
    tick(0, 0, 1);
    tick();
    chk("t3_hh_wrap", Disp_Data, 32'h00A59A10);
    tick(0, 1, 0);
    tick(0, 0, 1);
    tick();
    chk("t3_mm_wrap", Disp_Data, 32'h00A00A10);

    tick(1, 0, 0);
    chk("t4_in_alarm", 32'(Mode), 32'd2);
    repeat (TO) tick();
    chk("t4_mode", 32'(Mode), 32'd0);
    chk("t4_alarm", 32'(Alarm_BCD), 32'h070000);

    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(1, 0, 1);
    chk("t5_alarm", 32'(Alarm_BCD), 32'h090000);
    chk("t5_mode", 32'(Mode), 32'd0);

    tick(1, 0, 0);
    tick(0, 0, 1);
    tick(0, 1, 0);
    tick(0, 0, 1);
    Reset_n = 1'b0;
    #1;
    chk("t6_disp", Disp_Data, 32'h0);
    chk("t6_mode", 32'(Mode), 32'd0);
    chk("t6_load", 32'(Set_Time_Load), 32'd0);
    m_reset();
    @(posedge Clk);
    #1;
    chk_reset("t6_hold");
    Reset_n = 1'b1;
    tick();

    for (int seg = 0; seg < 8; seg++) begin
      dense = (seg % 2) == 0;
      repeat (400) begin
        r  = $urandom_range(0, 99);
        km = 1'b0;
        kn = 1'b0;
        ku = 1'b0;
        if (dense) begin
          km = r < 5;
          kn = r >= 5 && r < 15;
          ku = r >= 15 && r < 40;
          if ($urandom_range(0, 15) == 0) begin
            km = 1'($urandom_range(0, 1));
            kn = 1'($urandom_range(0, 1));
            ku = 1'($urandom_range(0, 1));
          end
        end else begin
          km = r == 1;
          ku = r == 0;
        end
        if ($urandom_range(0, 7) == 0)
          set_time($urandom_range(0, 23), $urandom_range(0, 59),
                   $urandom_range(0, 59));
        tick(km, kn, ku);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
